// File: rtl/scan_sequencer.sv
// Line-scan sequencer feeding a 3-to-8 decoder: walks the set bits of a mask in
// ascending order, each preceded by BLANK cycles with e=0 and driven for a dwell time.
module scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int BLANK   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         n,
    output logic               e,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    localparam int BLANK_W = $clog2(BLANK + 1);
    localparam int CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    // state_dbg encoding: 0 = IDLE, 1 = BLANK, 2 = DRIVE
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         n_d;
    logic               e_d, busy_d, done_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0]   dwell_last;
    logic [2:0]         first_in, first_q, next_q;
    logic               has_next;

    assign state_dbg  = state;
    assign dwell_last = CNT_W'(dwell_q) - CNT_W'(1);

    // Lowest set line of the incoming and latched masks, and next line above n.
    always_comb begin
        first_in = 3'd0;
        first_q  = 3'd0;
        next_q   = 3'd0;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) first_in = 3'(i);
            if (mask_q[i]) first_q = 3'(i);
            if (mask_q[i] && (3'(i) > n)) begin
                next_q   = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    // start/stop are level commands sampled on each edge: start counts only in IDLE
    // with stop low, stop wins everywhere; there is no ready/acknowledge path.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        n_d     = n;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (mask != 8'd0) begin
                        mask_d  = mask;
                        dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                        n_d     = first_in;
                        cnt_d   = '0;
                        state_d = S_BLANK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt == dwell_last) begin
                    cnt_d = '0;
                    if (has_next) begin
                        n_d     = next_q;
                        state_d = S_BLANK;
                    end else if (continuous) begin
                        n_d     = first_q;
                        state_d = S_BLANK;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        e_d    = (state_d == S_DRIVE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n       <= 3'd0;
            e       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mask_q  <= 8'd0;
            dwell_q <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            n       <= n_d;
            e       <= e_d;
            busy    <= busy_d;
            done    <= done_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a timing model predicts every driven line and done pulse,
// a negedge monitor compares what the sequencer (through a decoder) actually shows.
module tb_scan_sequencer;

    localparam int DWELL_W = 8;
    localparam int BLANK   = 1;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         n;
    logic               e;
    logic               busy;
    logic               done;
    logic [1:0]         state_dbg;
    logic [7:0]         d;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // line record: {n[2:0], length[7:0], first cycle with e=1 [28:0]}
    logic [39:0] line_q[$];
    logic [31:0] done_q[$];

    scan_sequencer #(.DWELL_W(DWELL_W), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .mask(mask), .dwell(dwell), .n(n), .e(e), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // downstream 3-to-8 decoder
    always_comb begin
        d = 8'd0;
        for (int i = 0; i < 8; i++) if (e && (n == 3'(i))) d[i] = 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Lines of a pass follow each other with period BLANK+dwell starting at the accepting
    // edge c0; cut is the edge at which an abort lands (0 = none).
    task automatic model_scan(input logic [7:0] m, input int dw, input bit cont,
                              input int c0, input int cut, output int fin);
        int dwe, t, st, len;
        dwe = (dw == 0) ? 1 : dw;
        t   = c0;
        fin = c0;
        if (m == 8'd0) begin
            done_q.push_back(32'(c0));
            return;
        end
        forever begin
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    st = t + BLANK;
                    if (cut != 0 && st >= cut) begin
                        fin = cut;
                        return;
                    end
                    len = (cut != 0 && st + dwe > cut) ? cut - st : dwe;
                    line_q.push_back({3'(i), 8'(len), 29'(st)});
                    t = t + BLANK + dwe;
                end
            end
            if (!cont) begin
                if (cut == 0 || t < cut) done_q.push_back(32'(t));
                fin = t;
                return;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where the pass (or abort) is complete,
    // so a following call starts back-to-back.
    task automatic run_scan(input logic [7:0] m, input int dw, input bit cont,
                            input int stop_after, input bit use_rst, input bit glitch);
        int c0, cut, fin;
        mask       = m;
        dwell      = DWELL_W'(dw);
        continuous = cont;
        start      = 1'b1;
        c0         = cyc + 1;
        cut        = (stop_after >= 0) ? c0 + stop_after + 1 : 0;
        model_scan(m, dw, cont, c0, cut, fin);
        @(negedge clk);
        start = 1'b0;
        if (glitch) begin
            wait_until(c0 + 4);
            start = 1'b1;
            mask  = 8'h01;
            dwell = '0;
            @(negedge clk);
            start = 1'b0;
        end
        if (stop_after >= 0) begin
            wait_until(c0 + stop_after);
            if (use_rst) rst = 1'b1;
            else         stop = 1'b1;
            @(negedge clk);
            rst  = 1'b0;
            stop = 1'b0;
            chk("abort_e", 32'(e), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            if (use_rst) begin
                chk("rst_n", 32'(n), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
        end else begin
            wait_until(fin);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a done pulse or ends an e run.
    initial begin
        bit          e_prev;
        int          run_start, run_len;
        logic [2:0]  run_n, en;
        logic [7:0]  el, oh;
        logic [28:0] es;
        logic [39:0] lt;
        logic [31:0] dc;
        e_prev = 1'b0;
        run_start = 0;
        run_len = 0;
        run_n = 3'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: done=1 at cycle %0d, none expected", cyc);
                    end else begin
                        dc = done_q.pop_front();
                        if (dc != 32'(cyc)) begin
                            errors++;
                            $display("FAIL done_time: got cycle %0d, expected %0d", cyc, dc);
                        end
                    end
                end
                if (e) begin
                    if (!e_prev) begin
                        run_n     = n;
                        run_start = cyc;
                        run_len   = 0;
                        if (line_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL line_unexpected: e=1 n=%0d at cycle %0d", n, cyc);
                        end
                    end
                    run_len++;
                    if (line_q.size() != 0) begin
                        lt = line_q[0];
                        en = lt[39:37];
                        oh = 8'd1;
                        oh = oh << en;
                        checks++;
                        if (n !== en || d !== oh) begin
                            errors++;
                            $display("FAIL line_drive: n=%0d d=%b, expected n=%0d d=%b", n, d, en, oh);
                        end
                    end
                end else if (e_prev && line_q.size() != 0) begin
                    lt = line_q.pop_front();
                    en = lt[39:37];
                    el = lt[36:29];
                    es = lt[28:0];
                    checks++;
                    if (run_n !== en || 8'(run_len) !== el || 29'(run_start) !== es) begin
                        errors++;
                        $display("FAIL line_run: n=%0d len=%0d at %0d, expected n=%0d len=%0d at %0d",
                                 run_n, run_len, run_start, en, el, es);
                    end
                end
                e_prev = e;
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        mask = 8'd0;
        dwell = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_n", 32'(n), 32'd0);
        chk("reset_e", 32'(e), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'd0);
        mon_en = 1'b1;

        // full mask with an ignored start mid-scan, then a sparse mask back-to-back
        run_scan(8'hFF, 2, 1'b0, -1, 1'b0, 1'b1);
        run_scan(8'hA4, 3, 1'b0, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("n_hold_last", 32'(n), 32'd7);
        chk("idle_busy", 32'(busy), 32'd0);

        // empty mask: done next cycle, never busy
        run_scan(8'h00, 5, 1'b0, -1, 1'b0, 1'b0);
        chk("empty_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // start together with stop in IDLE is ignored
        mask  = 8'hFF;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_e", 32'(e), 32'd0);

        // continuous 0,7,0,7... stopped while line 7 is driven
        run_scan(8'h81, 1, 1'b1, 11, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // dwell 0 behaves as 1
        run_scan(8'h01, 0, 1'b0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // reset while a line is driven
        run_scan(8'h3C, 4, 1'b0, 7, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        for (int it = 0; it < 24; it++) begin
            logic [7:0] rm;
            int         rd;
            bit         rc;
            int         sa;
            rm = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rd = $urandom_range(0, 5);
            rc = ($urandom_range(0, 3) == 0);
            sa = -1;
            if (rc || $urandom_range(0, 2) == 0) sa = $urandom_range(0, 40);
            run_scan(rm, rd, rc, sa, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("lines_pending", 32'(line_q.size()), 32'd0);
        chk("done_pending", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Upstream stage for the 3-to-8 line decoder: generates the `n[2:0]` select and `e` enable that the decoder turns into a one-hot `d[7:0]`. Steps the select through the lines enabled in a mask, in ascending order. Each line is driven for a programmable dwell time, and a blanking gap with `e=0` separates lines. A select change therefore never coincides with an enabled output. Supports single-pass and continuous scanning, with abort.

## Interface
- `DWELL_W`, 8, width of the dwell-count input.
- `BLANK`, 1, blanking cycles (`e=0`) before each line is driven; must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `stop`  in  1  abort a running scan; has priority over `start`.
- `continuous`  in  1  0 = single pass; 1 = repeat. Sampled at the end of each pass.
- `mask`  in  8  lines to visit; latched on accepted `start`.
- `dwell`  in  DWELL_W  cycles `e=1` per line; latched on accepted `start`; 0 is treated as 1.
- `n`  out  3  line select to the decoder.
- `e`  out  1  decoder enable.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion of a pass (single mode) or an empty-mask start.

## Operation
- Reset: state IDLE; `n=0`, `e=0`, `busy=0`, `done=0`; latched mask and dwell cleared.
- States:
  - IDLE: `e=0`, `busy=0`, `n` holds its last value.
  - BLANK: `e=0`; counts `BLANK` cycles.
  - DRIVE: `e=1`; counts the latched dwell.
- IDLE, `start=1`, `stop=0`:
  - If `mask!=0`: latch `mask` and `dwell`. `n` ← lowest set bit index. Go to BLANK.
  - If `mask==0`: stay in IDLE and pulse `done` on the next cycle. `busy` stays 0.
- BLANK → DRIVE after `BLANK` cycles.
- DRIVE, after the dwell expires:
  - If a higher set bit exists in the latched mask: `n` ← next higher set index, go to BLANK. Unset lines are skipped with zero cost.
  - Else, last line:
    - If `continuous=1`: `n` ← lowest set index, go to BLANK. No `done` pulse.
    - Else: go to IDLE with `done=1` for one cycle; `n` holds the last line.
- `stop=1` in BLANK or DRIVE: at the next edge go to IDLE. `e=0`, `busy=0`, no `done`, `n` holds.
- `stop=1` in IDLE: `start` is ignored.
- `start` in BLANK or DRIVE is ignored.
- Changes to `mask` or `dwell` during a scan have no effect until the next accepted `start`.
- Invariant: `n` changes only on an edge where `e` is 0 or becomes 0. `n` is constant while `e=1`.
- `e` and `n` are registered outputs (no combinational path from inputs).

## Timing
- Edge numbering: `start` is accepted at edge 0.
- Cycle after edge 0: `busy=1`, `n`=first line, `e=0`.
- `e` rises after edge `BLANK` and stays high for `dwell` cycles. It falls after edge `BLANK+dwell`, and `n` advances at that same edge.
- Per-line period is `BLANK+max(dwell,1)` cycles.
- Single pass over k lines: `done` is high in the cycle after edge `k*(BLANK+dwell)`. `busy` falls in that same cycle.
- Back-to-back passes: `start` is accepted in the same cycle `done` is high, so the new pass begins one cycle after the previous ends.
- Continuous wrap: no extra gap beyond the normal `BLANK`.
- `rst` mid-scan: outputs take their reset values after the next edge. `rst` overrides `start` and `stop`.

## Test plan
- Reset, then `mask=8'hFF`, `dwell=2`, `continuous=0`, pulse `start`:
  - `n` = 0..7 in order, each with `e=1` for exactly 2 cycles after 1 blank cycle.
  - `done` pulses 24 cycles after `start`.
  - Bench feeds the decoder and checks `d == 1<<n` while `e=1`, and `d==0` otherwise.
- `mask=8'b1010_0100`, `dwell=3`:
  - Visits `n`=2,5,7 only.
  - `done` after 12 cycles; `n` stays 7 afterward.
- `mask=0`, pulse `start`: `done=1` the next cycle, `busy=0`, `e` never rises.
- `continuous=1`, `mask=8'h81`, `dwell=1`:
  - `n` alternates 0,7,0,7 with `e` duty 1/2 and no `done`.
  - `stop` asserted while `e=1`: `e=0` and `busy=0` after the next edge, no `done`.
- `dwell=0` with `mask=8'h01`: behaves as `dwell=1` (one `e` cycle).
- Scan running, assert `rst` while `e=1`: next cycle `n=0`, `e=0`, `busy=0`, `done=0`.
  - Also check that `start` during `busy` and `start`+`stop` together in IDLE are both ignored.
